// File: rtl/simon2share_feeder.sv
// Job sequencer for the two-share bit-serial SIMON-128/128 core: masks a job,
// streams both shares MSB first, runs the core and returns the ciphertext.
module simon2share_feeder #(
    parameter int BLK_W   = 128,
    parameter int KEY_W   = 128,
    parameter int RUN_MAX = 160
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] pt,
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] mask_pt,
    input  logic [KEY_W-1:0] mask_key,
    output logic             core_data_ina,
    output logic             core_data_inb,
    output logic [1:0]       core_data_rdy,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_cipher,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BLK_W-1:0] res_data,
    output logic             err
);

    localparam int SW   = BLK_W + KEY_W;
    localparam int LMAX = (BLK_W > KEY_W) ? BLK_W : KEY_W;
    localparam int CMAX = (LMAX > RUN_MAX) ? LMAX : RUN_MAX;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PT,
        LOAD_KEY,
        RUN,
        RESULT
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]    cnt, cnt_n;
    logic [SW-1:0]    sa, sa_n;
    logic [SW-1:0]    sb, sb_n;
    logic [SW-1:0]    load_a, load_b;
    logic             ina_n, inb_n;
    logic [1:0]       rdy_n;
    logic             in_ready_n;
    logic             res_valid_n;
    logic [BLK_W-1:0] res_data_n;
    logic             err_n;

    // Share a carries the masked value, share b the mask itself.
    assign load_a = {pt ^ mask_pt, key ^ mask_key};
    assign load_b = {mask_pt, mask_key};

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sa_n        = sa;
        sb_n        = sb;
        ina_n       = 1'b0;
        inb_n       = 1'b0;
        rdy_n       = 2'd0;
        in_ready_n  = 1'b0;
        res_valid_n = res_valid;
        res_data_n  = res_data;
        err_n       = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    ina_n      = load_a[SW-1];
                    inb_n      = load_b[SW-1];
                    sa_n       = {load_a[SW-2:0], 1'b0};
                    sb_n       = {load_b[SW-2:0], 1'b0};
                    cnt_n      = '0;
                    rdy_n      = 2'd1;
                    in_ready_n = 1'b0;
                    state_n    = LOAD_PT;
                end
            end
            LOAD_PT: begin
                ina_n = sa[SW-1];
                inb_n = sb[SW-1];
                sa_n  = {sa[SW-2:0], 1'b0};
                sb_n  = {sb[SW-2:0], 1'b0};
                cnt_n = cnt + CW'(1);
                rdy_n = 2'd1;
                if (cnt == CW'(BLK_W - 1)) begin
                    cnt_n   = '0;
                    rdy_n   = 2'd2;
                    state_n = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                ina_n = sa[SW-1];
                inb_n = sb[SW-1];
                sa_n  = {sa[SW-2:0], 1'b0};
                sb_n  = {sb[SW-2:0], 1'b0};
                cnt_n = cnt + CW'(1);
                rdy_n = 2'd2;
                if (cnt == CW'(KEY_W - 1)) begin
                    ina_n   = 1'b0;
                    inb_n   = 1'b0;
                    sa_n    = '0;
                    sb_n    = '0;
                    cnt_n   = '0;
                    rdy_n   = 2'd3;
                    state_n = RUN;
                end
            end
            RUN: begin
                rdy_n = 2'd3;
                cnt_n = cnt + CW'(1);
                // A Done arriving on the timeout cycle still yields a result.
                if (core_done) begin
                    res_data_n  = core_cipher;
                    res_valid_n = 1'b1;
                    rdy_n       = 2'd0;
                    cnt_n       = '0;
                    state_n     = RESULT;
                end else if (cnt == CW'(RUN_MAX - 1)) begin
                    err_n      = 1'b1;
                    rdy_n      = 2'd0;
                    cnt_n      = '0;
                    in_ready_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            RESULT: begin
                if (res_valid && res_ready) begin
                    res_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                in_ready_n  = 1'b1;
                res_valid_n = 1'b0;
                cnt_n       = '0;
                state_n     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sa            <= '0;
            sb            <= '0;
            core_data_ina <= 1'b0;
            core_data_inb <= 1'b0;
            core_data_rdy <= 2'd0;
            in_ready      <= 1'b1;
            res_valid     <= 1'b0;
            res_data      <= '0;
            err           <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            sa            <= sa_n;
            sb            <= sb_n;
            core_data_ina <= ina_n;
            core_data_inb <= inb_n;
            core_data_rdy <= rdy_n;
            in_ready      <= in_ready_n;
            res_valid     <= res_valid_n;
            res_data      <= res_data_n;
            err           <= err_n;
        end
    end

endmodule

// File: tb/tb_simon2share_feeder.sv
// Bench for simon2share_feeder with a behavioural two-share core that
// recombines the serial shares and encrypts with a word-level SIMON model.
module tb_simon2share_feeder;

    localparam int BLK_W   = 128;
    localparam int KEY_W   = 128;
    localparam int RUN_MAX = 160;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BLK_W-1:0] pt = '0;
    logic [KEY_W-1:0] key = '0;
    logic [BLK_W-1:0] mask_pt = '0;
    logic [KEY_W-1:0] mask_key = '0;
    logic             core_data_ina;
    logic             core_data_inb;
    logic [1:0]       core_data_rdy;
    logic             core_done;
    logic [BLK_W-1:0] core_cipher;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [BLK_W-1:0] res_data;
    logic             err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simon2share_feeder #(
        .BLK_W(BLK_W),
        .KEY_W(KEY_W),
        .RUN_MAX(RUN_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pt(pt),
        .key(key),
        .mask_pt(mask_pt),
        .mask_key(mask_key),
        .core_data_ina(core_data_ina),
        .core_data_inb(core_data_inb),
        .core_data_rdy(core_data_rdy),
        .core_done(core_done),
        .core_cipher(core_cipher),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .err(err)
    );

    function automatic logic [63:0] rol(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    // SIMON-128/128: 68 rounds, z2 sequence, two-word key schedule.
    function automatic logic [127:0] simon_ref(input logic [127:0] p, input logic [127:0] k);
        logic [63:0] x, y, t, ka, kb, kn, z;
        x  = p[127:64];
        y  = p[63:0];
        ka = k[63:0];
        kb = k[127:64];
        z  = 64'h7369f885192c0ef5;
        for (int i = 0; i < 68; i++) begin
            t  = x;
            x  = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ ka;
            y  = t;
            kn = 64'hfffffffffffffffc ^ {63'd0, z[i % 62]} ^ ka ^ ror(kb, 3) ^ ror(kb, 4);
            ka = kb;
            kb = kn;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural core: gathers recombined shares, raises Done after stub_lat RUN cycles.
    logic [127:0] c_pt = '0;
    logic [127:0] c_key = '0;
    int           c_run = 0;
    int           stub_lat = -1;
    logic         junk_done = 1'b0;
    logic         stub_done;

    always @(posedge clk) begin
        case (core_data_rdy)
            2'd1: c_pt <= {c_pt[126:0], core_data_ina ^ core_data_inb};
            2'd2: c_key <= {c_key[126:0], core_data_ina ^ core_data_inb};
            2'd3: c_run <= c_run + 1;
            default: begin
                c_pt  <= '0;
                c_key <= '0;
                c_run <= 0;
            end
        endcase
    end

    assign stub_done   = (core_data_rdy == 2'd3) && (stub_lat >= 0) && (c_run == stub_lat);
    assign core_done   = stub_done | junk_done;
    assign core_cipher = simon_ref(c_pt, c_key);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One job: lat<0 means the core never finishes; hold cycles of res_ready=0;
    // junk drives in_valid and spurious core_done while the job is in flight.
    task automatic run_job(input string tag, input logic [127:0] p, input logic [127:0] k,
                           input logic [127:0] mp, input logic [127:0] mk,
                           input logic [127:0] exp_ct, input int lat, input int hold,
                           input bit junk);
        logic [255:0] ab;
        logic [255:0] bb;
        logic [127:0] held;
        int           bad;
        int           k_ev;
        int           w;
        bit           got_res;
        bit           got_err;
        ab = '0;
        bb = '0;
        bad = 0;
        k_ev = -1;
        got_res = 1'b0;
        got_err = 1'b0;
        stub_lat = lat;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        pt = p;
        key = k;
        mask_pt = mp;
        mask_key = mk;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = junk;
        pt = rnd128();
        key = rnd128();
        mask_pt = rnd128();
        mask_key = rnd128();
        for (int c = 0; c < 600; c++) begin
            if (c < 256) begin
                ab = {ab[254:0], core_data_ina ^ core_data_inb};
                bb = {bb[254:0], core_data_inb};
                if (core_data_rdy !== ((c < 128) ? 2'd1 : 2'd2)) bad++;
                if (in_ready !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0) bad++;
            end else begin
                if (res_valid === 1'b1) begin
                    got_res = 1'b1;
                    k_ev = c;
                    break;
                end
                if (err === 1'b1) begin
                    got_err = 1'b1;
                    k_ev = c;
                    break;
                end
                if (core_data_rdy !== 2'd3 || core_data_ina !== 1'b0 ||
                    core_data_inb !== 1'b0 || in_ready !== 1'b0) bad++;
            end
            junk_done = (junk && c < 255) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        junk_done = 1'b0;
        if (!junk) in_valid = 1'b0;
        chk({tag, "_seq"}, bad, 0);
        chk({tag, "_pt_bits"}, ab[255:128], p);
        chk({tag, "_key_bits"}, ab[127:0], k);
        chk({tag, "_b_share"}, bb, {mp, mk});
        if (lat >= 0 && lat < RUN_MAX) begin
            chk({tag, "_got_res"}, got_res, 1);
            chk({tag, "_latency"}, k_ev, 257 + lat);
            chk({tag, "_res_data"}, res_data, exp_ct);
            chk({tag, "_in_ready_res"}, in_ready, 0);
            held = res_data;
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                pt = rnd128();
                @(negedge clk);
                if (res_valid !== 1'b1 || res_data !== held || in_ready !== 1'b0 ||
                    core_data_rdy !== 2'd0 || err !== 1'b0) bad++;
            end
            if (hold > 0) chk({tag, "_hold"}, bad, 0);
            in_valid = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk({tag, "_res_drop"}, res_valid, 0);
            chk({tag, "_idle"}, in_ready, 1);
        end else begin
            in_valid = 1'b0;
            chk({tag, "_got_err"}, got_err, 1);
            chk({tag, "_err_time"}, k_ev, 256 + RUN_MAX);
            chk({tag, "_no_res"}, res_valid, 0);
            @(negedge clk);
            chk({tag, "_err_pulse"}, err, 0);
            chk({tag, "_idle"}, in_ready, 1);
            chk({tag, "_rdy0"}, core_data_rdy, 0);
        end
    endtask

    initial begin
        logic [127:0] p, k, mp, mk;
        int           lat;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rdy", core_data_rdy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err, 0);
        chk("rst_ina_inb", {core_data_ina, core_data_inb}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        p = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        run_job("msb", p, '0, '0, '0, simon_ref(p, '0), 70, 0, 1'b0);

        p = '1;
        mp = {32{4'hA}};
        run_job("ones", p, p, mp, mp, simon_ref(p, p), 40, 0, 1'b0);

        run_job("vector", 128'h63736564207372656c6c657661727420,
                128'h0f0e0d0c0b0a09080706050403020100, rnd128(), rnd128(),
                128'h49681b1e1e54fe3f65aa832af84e0bbc, 67, 0, 1'b0);

        run_job("timeout", rnd128(), rnd128(), rnd128(), rnd128(), '0, -1, 0, 1'b0);

        p = rnd128();
        k = rnd128();
        run_job("hold", p, k, rnd128(), rnd128(), simon_ref(p, k), 55, 20, 1'b1);

        p = rnd128();
        k = rnd128();
        run_job("lat0", p, k, rnd128(), rnd128(), simon_ref(p, k), 0, 0, 1'b0);

        p = rnd128();
        k = rnd128();
        run_job("done_at_limit", p, k, rnd128(), rnd128(), simon_ref(p, k),
                RUN_MAX - 1, 2, 1'b0);

        for (int j = 0; j < 3; j++) begin
            p = rnd128();
            k = rnd128();
            mp = rnd128();
            mk = rnd128();
            lat = $urandom_range(1, 150);
            run_job($sformatf("rand%0d", j), p, k, mp, mk, simon_ref(p, k), lat, 3, 1'b1);
        end

        // Reset in the middle of the plaintext load aborts the job.
        stub_lat = 60;
        pt = rnd128();
        key = rnd128();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("midload_rdy", core_data_rdy, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_rdy", core_data_rdy, 0);
        chk("midrst_ina_inb", {core_data_ina, core_data_inb}, 0);
        chk("midrst_res_valid", res_valid, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {in_ready, core_data_rdy, res_valid, err}, 5'b10000);

        p = rnd128();
        k = rnd128();
        run_job("after_rst", p, k, rnd128(), rnd128(), simon_ref(p, k), 30, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
